matrix_mac_engine: RTL and testbench

//   Producer side of the matrix_result/matrix_valid stream consumed by neural_layer.

---
 rtl/matrix_mac_engine.sv | 210 +++++++++++++++++++++
 tb/tb_matrix_mac_engine.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mac_engine.sv
// matrix_mac_engine: computes C = A*B with one signed MAC and streams C row-major.
// A (MxN) and B (NxP) live in local register files that are writable only while idle.
// Each C element costs N MAC cycles plus one EMIT cycle. EMIT holds the saturated
// result until the consumer takes it. A one-cycle done pulse follows the last beat.
module matrix_mac_engine #(
   parameter int M          = 3,
   parameter int N          = 3,
   parameter int P          = 3,
   parameter int DATA_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        a_wen,
   input  logic [$clog2(M*N)-1:0]      a_addr,
   input  logic [DATA_WIDTH-1:0]       a_data,
   input  logic                        b_wen,
   input  logic [$clog2(N*P)-1:0]      b_addr,
   input  logic [DATA_WIDTH-1:0]       b_data,
   input  logic                        start,
   input  logic                        result_ready,
   output logic [2*DATA_WIDTH-1:0]     matrix_result,
   output logic                        matrix_valid,
   output logic [$clog2(M)-1:0]        result_row,
   output logic [$clog2(P)-1:0]        result_col,
   output logic                        busy,
   output logic                        done
);

   localparam int RW    = $clog2(M);
   localparam int CW    = $clog2(P);
   localparam int KW    = $clog2(N);
   localparam int AAW   = $clog2(M*N);
   localparam int BAW   = $clog2(N*P);
   localparam int PW    = 2*DATA_WIDTH;
   localparam int ACC_W = 2*DATA_WIDTH + $clog2(N) + 1;

   localparam logic [RW-1:0]  I_LAST = RW'(M-1);
   localparam logic [CW-1:0]  J_LAST = CW'(P-1);
   localparam logic [KW-1:0]  K_LAST = KW'(N-1);
   localparam logic [AAW-1:0] A_LAST = AAW'(M*N-1);
   localparam logic [BAW-1:0] B_LAST = BAW'(N*P-1);

   // Saturation bounds of the 2*DATA_WIDTH result, expressed at accumulator width.
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-PW+1){1'b0}}, {(PW-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-PW+1){1'b1}}, {(PW-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_EMIT,
      S_DONE
   } state_t;

   state_t                    state_q, state_d;
   logic [RW-1:0]             i_q, i_d;
   logic [CW-1:0]             j_q, j_d;
   logic [KW-1:0]             k_q, k_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;

   logic signed [DATA_WIDTH-1:0] a_mem_q [M*N];
   logic signed [DATA_WIDTH-1:0] b_mem_q [N*P];

   logic [AAW-1:0]            a_idx;
   logic [BAW-1:0]            b_idx;
   logic signed [PW-1:0]      a_ext;
   logic signed [PW-1:0]      b_ext;
   logic signed [PW-1:0]      prod;
   logic signed [ACC_W-1:0]   prod_ext;
   logic [PW-1:0]             sat_result;

   // A register file: cleared on reset, written only while idle and in range.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int x = 0; x < M*N; x++) begin
            a_mem_q[x] <= '0;
         end
      end else if (state_q == S_IDLE && a_wen && a_addr <= A_LAST) begin
         a_mem_q[a_addr] <= a_data;
      end
   end

   // B register file: cleared on reset, written only while idle and in range.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int x = 0; x < N*P; x++) begin
            b_mem_q[x] <= '0;
         end
      end else if (state_q == S_IDLE && b_wen && b_addr <= B_LAST) begin
         b_mem_q[b_addr] <= b_data;
      end
   end

   // Operand fetch and full-precision signed product for the current (i,k,j) step.
   // Operands are widened first so the product never overflows PW bits.
   always_comb begin
      a_idx    = AAW'(int'(i_q) * N + int'(k_q));
      b_idx    = BAW'(int'(k_q) * P + int'(j_q));
      a_ext    = {{DATA_WIDTH{a_mem_q[a_idx][DATA_WIDTH-1]}}, a_mem_q[a_idx]};
      b_ext    = {{DATA_WIDTH{b_mem_q[b_idx][DATA_WIDTH-1]}}, b_mem_q[b_idx]};
      prod     = a_ext * b_ext;
      prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
   end

   // Clamp the accumulator into the signed 2*DATA_WIDTH output range.
   always_comb begin
      if (acc_q > SAT_MAX) begin
         sat_result = {1'b0, {(PW-1){1'b1}}};
      end else if (acc_q < SAT_MIN) begin
         sat_result = {1'b1, {(PW-1){1'b0}}};
      end else begin
         sat_result = acc_q[PW-1:0];
      end
   end

   // State, index counters and accumulator registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
      end
   end

   // Next-state and output decode; outputs depend on registered state only,
   // so an asynchronous reset drops valid/busy/done at once.
   always_comb begin
      state_d       = state_q;
      i_d           = i_q;
      j_d           = j_q;
      k_d           = k_q;
      acc_d         = acc_q;
      matrix_result = '0;
      matrix_valid  = 1'b0;
      result_row    = '0;
      result_col    = '0;
      busy          = 1'b0;
      done          = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_MAC;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               acc_d   = '0;
            end
         end

         S_MAC: begin
            busy  = 1'b1;
            acc_d = acc_q + prod_ext;
            if (k_q == K_LAST) begin
               k_d     = '0;
               state_d = S_EMIT;
            end else begin
               k_d = k_q + KW'(1);
            end
         end

         S_EMIT: begin
            busy          = 1'b1;
            matrix_valid  = 1'b1;
            matrix_result = sat_result;
            result_row    = i_q;
            result_col    = j_q;
            if (result_ready) begin
               if (i_q == I_LAST && j_q == J_LAST) begin
                  state_d = S_DONE;
               end else begin
                  if (j_q == J_LAST) begin
                     j_d = '0;
                     i_d = i_q + RW'(1);
                  end else begin
                     j_d = j_q + CW'(1);
                  end
                  k_d     = '0;
                  acc_d   = '0;
                  state_d = S_MAC;
               end
            end
         end

         S_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            acc_d   = '0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Testbench for matrix_mac_engine (M=N=P=3, DATA_WIDTH=8).
// Expected C elements come from a plain-arithmetic matrix product with clamping.
module tb_matrix_mac_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_wen = 1'b0;
   logic [3:0]  a_addr = '0;
   logic [7:0]  a_data = '0;
   logic        b_wen = 1'b0;
   logic [3:0]  b_addr = '0;
   logic [7:0]  b_data = '0;
   logic        start = 1'b0;
   logic        result_ready = 1'b0;
   logic [15:0] matrix_result;
   logic        matrix_valid;
   logic [1:0]  result_row;
   logic [1:0]  result_col;
   logic        busy;
   logic        done;

   matrix_mac_engine #(.M(3), .N(3), .P(3), .DATA_WIDTH(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .a_wen         (a_wen),
      .a_addr        (a_addr),
      .a_data        (a_data),
      .b_wen         (b_wen),
      .b_addr        (b_addr),
      .b_data        (b_data),
      .start         (start),
      .result_ready  (result_ready),
      .matrix_result (matrix_result),
      .matrix_valid  (matrix_valid),
      .result_row    (result_row),
      .result_col    (result_col),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          a_val;
      int          b_val;
      logic [15:0] exp_c;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   int          ma [9];
   int          mb [9];
   logic [15:0] exp_arr [9];
   vec_t        vecs [8];

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   // Reference: C[r][c] = sum_k A[r][k]*B[k][c], clamped to 16-bit signed.
   function automatic logic [15:0] ref_c(input int r, input int c);
      int s = 0;
      for (int k = 0; k < 3; k++) s += ma[r*3+k] * mb[k*3+c];
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return 16'(s);
   endfunction

   function automatic void fill_exp_from_model();
      for (int b = 0; b < 9; b++) exp_arr[b] = ref_c(b / 3, b % 3);
   endfunction

   task automatic load_ab();
      for (int x = 0; x < 9; x++) begin
         @(negedge clk);
         a_wen = 1'b1; a_addr = 4'(x); a_data = 8'(ma[x]);
         b_wen = 1'b1; b_addr = 4'(x); b_data = 8'(mb[x]);
      end
      @(negedge clk);
      a_wen = 1'b0;
      b_wen = 1'b0;
   endtask

   // mode 0: ready always high, timing checked
   // mode 1: random ready
   // mode 2: ready low for 5 cycles on the 2nd beat
   // mode 3: start/writes pulsed while busy and start pulsed in the done cycle
   // mode 4: reset asserted during the 5th beat
   task automatic run_op(input int mode);
      int          n = 0;
      int          beat = 0;
      int          stall = 0;
      int          done_cnt = 0;
      bit          finished = 0;
      bit          aborted = 0;
      bit          prev_hold = 0;
      logic [15:0] prev_res = '0;
      logic [1:0]  prev_row = '0;
      logic [1:0]  prev_col = '0;

      @(negedge clk);
      start = 1'b1;
      while (!finished && n < 600) begin
         @(negedge clk);
         n++;
         if (n == 1) start = 1'b0;
         if (mode == 3 && n == 6) begin
            start = 1'b1;
            a_wen = 1'b1; a_addr = 4'd0; a_data = 8'h37;
            b_wen = 1'b1; b_addr = 4'd4; b_data = 8'h37;
         end else if (mode == 3 && n == 7) begin
            start = 1'b0; a_wen = 1'b0; b_wen = 1'b0;
         end

         case (mode)
            1: result_ready = 1'($urandom_range(1));
            2: begin
               result_ready = !(matrix_valid && beat == 1 && stall < 5);
               if (!result_ready) stall++;
            end
            default: result_ready = 1'b1;
         endcase

         if (mode == 4 && matrix_valid && beat == 4) begin
            rst_n = 1'b0;
            #1;
            chk("rst_valid_drop", int'(matrix_valid), 0);
            chk("rst_busy_drop", int'(busy), 0);
            chk("rst_done_low", int'(done), 0);
            @(negedge clk);
            rst_n = 1'b1;
            aborted = 1;
            break;
         end

         if (prev_hold) begin
            chk("hold_valid", int'(matrix_valid), 1);
            chk("hold_result", int'(matrix_result), int'(prev_res));
            chk("hold_row", int'(result_row), int'(prev_row));
            chk("hold_col", int'(result_col), int'(prev_col));
         end

         if (matrix_valid && result_ready) begin
            if (beat < 9) begin
               chk("result", int'(matrix_result), int'(exp_arr[beat]));
               chk("row", int'(result_row), beat / 3);
               chk("col", int'(result_col), beat % 3);
               if (mode == 0) chk("beat_time", n, 4 * (beat + 1));
            end
            beat++;
         end
         if (matrix_valid) chk("busy_in_emit", int'(busy), 1);

         prev_hold = matrix_valid && !result_ready;
         prev_res  = matrix_result;
         prev_row  = result_row;
         prev_col  = result_col;

         if (done) begin
            done_cnt++;
            finished = 1;
            chk("busy_in_done", int'(busy), 1);
            chk("valid_in_done", int'(matrix_valid), 0);
            if (mode == 0) chk("done_time", n, 37);
            if (mode == 3) start = 1'b1;
         end
      end

      if (!aborted) begin
         if (!finished) chk("timeout_done", 0, 1);
         chk("beat_count", beat, 9);
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) done_cnt++;
            chk("idle_busy", int'(busy), 0);
            chk("idle_valid", int'(matrix_valid), 0);
         end
         chk("done_pulses", done_cnt, 1);
      end
      $display("op mode %0d: %0d beats, %0d cycles%s", mode, beat, n,
               aborted ? ", aborted by reset" : "");
   endtask

   task automatic set_identity_seq();
      for (int x = 0; x < 9; x++) begin
         ma[x] = (x % 4 == 0) ? 1 : 0;
         mb[x] = x + 1;
      end
      for (int b = 0; b < 9; b++) exp_arr[b] = 16'(b + 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{-128, -128, 16'h7FFF};
      vecs[1] = '{-128,  127, 16'h8000};
      vecs[2] = '{ 127,  127, 16'h7FFF};
      vecs[3] = '{   2,    3, 16'h0012};
      vecs[4] = '{  -5,    7, 16'hFF97};
      vecs[5] = '{ 100,  100, 16'h7530};
      vecs[6] = '{-100,  100, 16'h8AD0};
      vecs[7] = '{   0, -128, 16'h0000};

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_valid", int'(matrix_valid), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_result", int'(matrix_result), 0);
      chk("reset_row", int'(result_row), 0);
      chk("reset_col", int'(result_col), 0);
      rst_n = 1'b1;

      // Identity times 1..9, then backpressure, then ignored inputs
      set_identity_seq();
      load_ab();
      run_op(0);
      run_op(2);
      run_op(3);
      run_op(0);

      // Uniform-matrix vectors including saturation corners
      for (int v = 0; v < 8; v++) begin
         for (int x = 0; x < 9; x++) begin
            ma[x] = vecs[v].a_val;
            mb[x] = vecs[v].b_val;
         end
         for (int b = 0; b < 9; b++) exp_arr[b] = vecs[v].exp_c;
         load_ab();
         run_op(0);
      end

      // Random operands with random backpressure
      for (int r = 0; r < 5; r++) begin
         for (int x = 0; x < 9; x++) begin
            ma[x] = ($urandom_range(3) == 0) ? -128 : int'($urandom_range(255)) - 128;
            mb[x] = ($urandom_range(3) == 0) ? 127 : int'($urandom_range(255)) - 128;
         end
         fill_exp_from_model();
         load_ab();
         run_op(1);
      end

      // Reset during the 5th beat; register files must come back cleared
      run_op(4);
      for (int x = 0; x < 9; x++) begin
         ma[x] = 0;
         mb[x] = 0;
      end
      fill_exp_from_model();
      run_op(0);
      set_identity_seq();
      load_ab();
      run_op(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
